// File: rtl/iomem_arbiter_if.sv
// ---------------------------------------------------------------------------
// iomem_arbiter_if
// Bundles the three requester ports (VGA read, CPU read/write, KBD write),
// the grant indicator and the single-port I/O memory bus that the arbiter
// drives.
//   slave  modport : the arbiter (samples requests and mem_q, drives
//                    completions, read data, memory address/data/we, grant_id)
//   master modport : the environment (requesters plus the memory instance)
// ---------------------------------------------------------------------------
interface iomem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // VGA character fetch (read-only)
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_done;
    logic [DATA_W-1:0] vga_rdata;

    // Processor (load/store)
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    // PS/2 keyboard writer (write-only)
    logic              kbd_req;
    logic [ADDR_W-1:0] kbd_addr;
    logic [DATA_W-1:0] kbd_wdata;
    logic              kbd_done;

    // I/O memory bus
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q;

    // 0 = none, 1 = VGA, 2 = CPU, 3 = KBD
    logic [1:0]        grant_id;

    modport slave (
        input  vga_req, vga_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  kbd_req, kbd_addr, kbd_wdata,
        input  mem_q,
        output vga_done, vga_rdata,
        output cpu_done, cpu_rdata,
        output kbd_done,
        output mem_addr, mem_wdata, mem_we,
        output grant_id
    );

    modport master (
        output vga_req, vga_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output kbd_req, kbd_addr, kbd_wdata,
        output mem_q,
        input  vga_done, vga_rdata,
        input  cpu_done, cpu_rdata,
        input  kbd_done,
        input  mem_addr, mem_wdata, mem_we,
        input  grant_id
    );
endinterface

// File: rtl/iomem_arbiter.sv
// ---------------------------------------------------------------------------
// iomem_arbiter
// Serialises VGA, CPU and KBD requests into one-at-a-time transactions on a
// single-port I/O memory with a one-cycle registered read.
// VGA has absolute priority; CPU and KBD share a one-bit round-robin pointer.
// Sequence per transaction: IDLE (sample/latch) -> ACCESS -> [WAIT] -> DONE.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : iomem_arbiter_if.slave (requesters, completions, memory bus)
// All outputs are registered.
// ---------------------------------------------------------------------------
module iomem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    iomem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_KBD  = 2'd3
    } grant_t;

    state_t            state_q, state_d;
    grant_t            grant_q, grant_d;
    grant_t            winner;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rr_kbd_q, rr_kbd_d;   // 1 = KBD favoured on a CPU/KBD tie
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              done_set;             // transaction completes this cycle
    logic              vga_done_q, cpu_done_q, kbd_done_q;

    // Winner among the live requests; only consumed while IDLE.
    always_comb begin
        winner = GNT_NONE;
        if (bus.vga_req)
            winner = GNT_VGA;
        else if (bus.cpu_req && !(bus.kbd_req && rr_kbd_q))
            winner = GNT_CPU;
        else if (bus.kbd_req)
            winner = GNT_KBD;
    end

    // Next-state and next-register values.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; that is what keeps this block free of inferred latches.
        state_d     = state_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rr_kbd_d    = rr_kbd_q;
        vga_rdata_d = vga_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        done_set    = 1'b0;

        case (state_q)
            IDLE: begin
                case (winner)
                    GNT_VGA: begin
                        // Read-only port: write data keeps its last value.
                        addr_d = bus.vga_addr;
                        we_d   = 1'b0;
                    end
                    GNT_CPU: begin
                        addr_d   = bus.cpu_addr;
                        wdata_d  = bus.cpu_wdata;
                        we_d     = bus.cpu_we;
                        rr_kbd_d = 1'b1;
                    end
                    GNT_KBD: begin
                        addr_d   = bus.kbd_addr;
                        wdata_d  = bus.kbd_wdata;
                        we_d     = 1'b1;
                        rr_kbd_d = 1'b0;
                    end
                    default: ;
                endcase
                if (winner != GNT_NONE) begin
                    grant_d = winner;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Memory samples the bus at the end of this cycle.
                we_d = 1'b0;
                if (we_q) begin
                    done_set = 1'b1;
                    state_d  = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // mem_q is valid now; only VGA and CPU ever read.
                if (grant_q == GNT_VGA)
                    vga_rdata_d = bus.mem_q;
                else
                    cpu_rdata_d = bus.mem_q;
                done_set = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                grant_d = GNT_NONE;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the address/data/read-data registers are ordinary flops
            // with defined reset values, not a storage array, so they are
            // reset along with the control state.
            state_q     <= IDLE;
            grant_q     <= GNT_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rr_kbd_q    <= 1'b0;
            vga_rdata_q <= '0;
            cpu_rdata_q <= '0;
            vga_done_q  <= 1'b0;
            cpu_done_q  <= 1'b0;
            kbd_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rr_kbd_q    <= rr_kbd_d;
            vga_rdata_q <= vga_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            // Done pulses for exactly the DONE cycle, routed to the winner.
            vga_done_q  <= done_set && (grant_q == GNT_VGA);
            cpu_done_q  <= done_set && (grant_q == GNT_CPU);
            kbd_done_q  <= done_set && (grant_q == GNT_KBD);
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q;
    assign bus.grant_id  = grant_q;
    assign bus.vga_done  = vga_done_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.kbd_done  = kbd_done_q;
    assign bus.vga_rdata = vga_rdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iomem_arbiter
// Directed steps (reset, contention, CPU store/load, KBD burst, abort)
// followed by randomized request sets. Expected grant order, data and timing
// come from a transaction-level model: a pending-requester set, a one-bit
// "CPU favoured" flag and a reference copy of memory contents.
// ---------------------------------------------------------------------------
module tb_iomem_arbiter;

    localparam int MEM_WORDS = 1024;

    logic clk = 1'b0;
    logic rst;

    iomem_arbiter_if bus ();

    iomem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Power-up content of the I/O memory.
    function automatic logic [15:0] init_val(input logic [9:0] a);
        if (a == 10'h020)
            return 16'h1234;
        return 16'(32'(a) * 37 + 5);
    endfunction

    // Memory instance: writes on mem_we, one-cycle registered read.
    logic [15:0] mem     [MEM_WORDS];
    bit          written [MEM_WORDS];
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr[9:0]]     <= bus.mem_wdata;
            written[bus.mem_addr[9:0]] <= 1'b1;
        end
        bus.mem_q <= written[bus.mem_addr[9:0]] ? mem[bus.mem_addr[9:0]]
                                                : init_val(bus.mem_addr[9:0]);
    end

    // Reference model state.
    logic [15:0] ref_mem [MEM_WORDS];
    bit          fav_cpu;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   grant_cyc = 0;
    logic prev_we = 1'b0;

    // Stimulus copies per port.
    logic [15:0] va, ca, cwd, ka, kwd;
    logic        cwe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mem_we may never be high in two consecutive cycles.
    always @(negedge clk) begin
        if (prev_we === 1'b1)
            check("we_back_to_back", 32'(bus.mem_we), 32'(0));
        prev_we = bus.mem_we;
    end

    function automatic logic [2:0] done_vec();
        return {bus.kbd_done, bus.cpu_done, bus.vga_done};
    endfunction

    function automatic logic [15:0] rdata_of(input int id);
        return (id == 1) ? bus.vga_rdata : bus.cpu_rdata;
    endfunction

    task automatic drive(input int id);
        case (id)
            1: begin bus.vga_addr = va; bus.vga_req = 1'b1; end
            2: begin
                bus.cpu_addr = ca; bus.cpu_wdata = cwd; bus.cpu_we = cwe;
                bus.cpu_req = 1'b1;
            end
            default: begin bus.kbd_addr = ka; bus.kbd_wdata = kwd; bus.kbd_req = 1'b1; end
        endcase
    endtask

    task automatic undrive(input int id);
        case (id)
            1: bus.vga_req = 1'b0;
            2: bus.cpu_req = 1'b0;
            default: bus.kbd_req = 1'b0;
        endcase
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  32'(bus.mem_addr),  32'(0));
        check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(0));
        check({tag, "_ctl"},   32'({bus.mem_we, bus.grant_id, done_vec()}), 32'(0));
        check({tag, "_vrd"},   32'(bus.vga_rdata), 32'(0));
        check({tag, "_crd"},   32'(bus.cpu_rdata), 32'(0));
    endtask

    // One complete transaction for requester id, starting with the sampling
    // edge. Expected fields come from the stimulus copies and ref_mem.
    task automatic do_txn(input int id);
        logic [15:0] a, wd, exp_rd;
        logic        we;
        logic [2:0]  dmask;
        dmask = 3'(1 << (id - 1));
        case (id)
            1:       begin a = va; wd = 16'h0; we = 1'b0; end
            2:       begin a = ca; wd = cwd;   we = cwe;  end
            default: begin a = ka; wd = kwd;   we = 1'b1; end
        endcase
        exp_rd = ref_mem[a[9:0]];

        tick();                                   // sampling edge -> ACCESS
        grant_cyc = cyc;
        check("grant",     32'(bus.grant_id), 32'(id));
        check("mem_addr",  32'(bus.mem_addr), 32'(a));
        check("we_access", 32'(bus.mem_we),   32'(we));
        if (we)
            check("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
        check("done_early", 32'(done_vec()), 32'(0));

        tick();                                   // -> DONE (write) / WAIT (read)
        check("we_cleared", 32'(bus.mem_we),   32'(0));
        check("grant_hold", 32'(bus.grant_id), 32'(id));
        if (!we) begin
            check("done_in_wait", 32'(done_vec()), 32'(0));
            tick();                               // -> DONE
            check("grant_hold_rd", 32'(bus.grant_id), 32'(id));
            check("rdata", 32'(rdata_of(id)), 32'(exp_rd));
        end
        check("done_pulse", 32'(done_vec()), 32'(dmask));

        tick();                                   // -> IDLE
        check("done_drop",   32'(done_vec()),     32'(0));
        check("grant_clear", 32'(bus.grant_id),   32'(0));
        if (!we)
            check("rdata_hold", 32'(rdata_of(id)), 32'(exp_rd));

        if (we)
            ref_mem[a[9:0]] = wd;
        if (id == 2)
            fav_cpu = 1'b0;
        else if (id == 3)
            fav_cpu = 1'b1;
        undrive(id);
    endtask

    initial begin
        int  mask;
        bit  pv, pc, pk;
        int  pick;
        int  prev_cyc;

        for (int i = 0; i < MEM_WORDS; i++)
            ref_mem[i] = init_val(10'(i));
        fav_cpu = 1'b1;

        bus.vga_req = 1'b0; bus.cpu_req = 1'b0; bus.kbd_req = 1'b0;
        bus.vga_addr = '0; bus.cpu_addr = '0; bus.kbd_addr = '0;
        bus.cpu_we = 1'b0; bus.cpu_wdata = '0; bus.kbd_wdata = '0;

        // Reset held for two cycles with every requester asserting.
        rst = 1'b1;
        va = 16'h0040;
        ca = 16'h0050; cwe = 1'b1; cwd = 16'hA5A5;
        ka = 16'h0060; kwd = 16'h0077;
        drive(1); drive(2); drive(3);
        tick(); check_all_zero("rst1");
        tick(); check_all_zero("rst2");
        rst = 1'b0;

        // Contention: VGA first, then CPU/KBD alternate while VGA idles.
        do_txn(1);
        do_txn(2);
        ca = 16'h0050; cwe = 1'b0; drive(2);      // CPU re-requests (load back)
        do_txn(3);
        ka = 16'h0061; kwd = 16'h0088; drive(3);  // KBD re-requests
        do_txn(2);
        do_txn(3);

        // CPU store.
        ca = 16'h0010; cwe = 1'b1; cwd = 16'hBEEF; drive(2);
        do_txn(2);
        check("mem_store", 32'(mem[16]), 32'(16'hBEEF));

        // CPU load of preloaded word; data held after done.
        ca = 16'h0020; cwe = 1'b0; drive(2);
        do_txn(2);
        tick();
        check("load_held", 32'(bus.cpu_rdata), 32'(16'h1234));

        // KBD burst: four writes, one every 3 cycles.
        prev_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            ka = 16'(16'h0100 + i); kwd = 16'($urandom); drive(3);
            do_txn(3);
            if (i > 0)
                check("kbd_spacing", 32'(grant_cyc - prev_cyc), 32'(3));
            prev_cyc = grant_cyc;
        end

        // Abort a VGA read during WAIT.
        va = 16'h0003; drive(1);
        tick();
        check("abort_grant", 32'(bus.grant_id), 32'(1));
        tick();
        check("abort_in_wait", 32'(done_vec()), 32'(0));
        rst = 1'b1;
        tick();
        check_all_zero("abort");
        rst = 1'b0;
        undrive(1);
        fav_cpu = 1'b1;
        tick();
        check("abort_no_done", 32'({bus.mem_we, done_vec()}), 32'(0));
        ca = 16'h0030; cwe = 1'b1; cwd = 16'h5A5A; drive(2);
        do_txn(2);

        // Randomized request sets, served per the priority model.
        for (int n = 0; n < 40; n++) begin
            mask = $urandom_range(1, 7);
            pv = mask[0]; pc = mask[1]; pk = mask[2];
            va  = 16'($urandom_range(0, MEM_WORDS - 1));
            ca  = 16'($urandom_range(0, MEM_WORDS - 1));
            cwe = 1'($urandom_range(0, 1));
            cwd = 16'($urandom);
            ka  = 16'($urandom_range(0, MEM_WORDS - 1));
            kwd = 16'($urandom);
            if (pv) drive(1);
            if (pc) drive(2);
            if (pk) drive(3);
            while (pv || pc || pk) begin
                if (pv)
                    pick = 1;
                else if (pc && (!pk || fav_cpu))
                    pick = 2;
                else
                    pick = 3;
                do_txn(pick);
                case (pick)
                    1:       pv = 1'b0;
                    2:       pc = 1'b0;
                    default: pk = 1'b0;
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
